// File: rtl/pmem_arbiter.sv
// Two-way arbiter sharing one physical-memory port between the I-cache and the D-cache.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; default build gives the D-cache fixed priority.
module pmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    logic   last_grant_d;
    logic   d_req;
    logic   pick_d;
    logic   done;

    assign d_req = d_pmem_read | d_pmem_write;
    assign done  = (state != IDLE) && pmem_resp;

`ifdef ARB_ROUND_ROBIN_EN
    // On contention the side that did not win last time goes next.
    assign pick_d = d_req & (~i_pmem_read | ~last_grant_d);
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
        end else begin
            last_grant_d <= done ? (state == SERVE_D) : last_grant_d;
            case (state)
                IDLE: begin
                    if (pick_d)
                        state <= SERVE_D;
                    else if (i_pmem_read)
                        state <= SERVE_I;
                end
                SERVE_I: if (pmem_resp) state <= IDLE;
                SERVE_D: if (pmem_resp) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    // Everything is forced quiet while rst is high, so a resp arriving during reset is dropped.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        if (!rst) begin
            case (state)
                SERVE_I: begin
                    pmem_read    = i_pmem_read;
                    pmem_address = i_pmem_address;
                    i_pmem_resp  = pmem_resp;
                end
                SERVE_D: begin
                    pmem_read    = d_pmem_read & ~d_pmem_write;
                    pmem_write   = d_pmem_write;
                    pmem_address = d_pmem_address;
                    pmem_wdata   = d_pmem_wdata;
                    d_pmem_resp  = pmem_resp;
                end
                default: ;
            endcase
        end
    end

endmodule
